plane_motion_ctrl: RTL and testbench



---
 rtl/plane_motion_ctrl_if.sv | 29 ++
 rtl/plane_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_plane_motion_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/plane_motion_ctrl_if.sv
// plane_motion_ctrl_if: bus between input conditioning, the motion controller and the plane datapath.
interface plane_motion_ctrl_if;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        button_c;
    logic        button_u;
    logic        button_d;
    logic        button_l;
    logic        button_r;
    logic [7:0]  accel_x;
    logic [7:0]  accel_y;
    logic [9:0]  obj_h;
    logic [9:0]  obj_v;
    logic        logo_active;
    logic [1:0]  regime;
    logic        frame_tick;
    logic [7:0]  accel_x_frame;
    logic [7:0]  accel_y_frame;

    modport master (
        output h_coord, v_coord, button_c, button_u, button_d, button_l, button_r, accel_x, accel_y,
        input  obj_h, obj_v, logo_active, regime, frame_tick, accel_x_frame, accel_y_frame
    );

    modport slave (
        input  h_coord, v_coord, button_c, button_u, button_d, button_l, button_r, accel_x, accel_y,
        output obj_h, obj_v, logo_active, regime, frame_tick, accel_x_frame, accel_y_frame
    );
endinterface

// File: rtl/plane_motion_ctrl.sv
// plane_motion_ctrl: frame-synchronous splash/buttons/accelerometer sequencer for the game-plane object.
// Define PLANE_SPLASH_EN to include the splash state; without it reset enters BUTTONS directly.
module plane_motion_ctrl #(
    parameter int                 H_MAX             = 799,
    parameter int                 V_MAX             = 599,
    parameter int                 OBJ_W             = 61,
    parameter int                 OBJ_H             = 50,
    parameter int                 FRAMES_PER_ACTION = 2,
    parameter logic [31:0]        SPLASH_CYCLES     = 32'h0600_0000,
    parameter int                 SPEED             = 1,
    parameter logic signed [7:0]  ACCEL_DZ          = 8'sd0
) (
    input logic              pixel_clk,
    input logic              rst,
    plane_motion_ctrl_if.slave bus
);
    // State encoding doubles as the regime output code.
    typedef enum logic [1:0] {
`ifdef PLANE_SPLASH_EN
        SPLASH  = 2'b00,
`endif
        BUTTONS = 2'b11,
        ACCEL   = 2'b10
    } state_t;

    localparam state_t RST_ST =
`ifdef PLANE_SPLASH_EN
        SPLASH;
`else
        BUTTONS;
`endif

    localparam logic [9:0]        H_LAST   = 10'(H_MAX);
    localparam logic [9:0]        V_LAST   = 10'(V_MAX);
    localparam logic [10:0]       H_LIM    = 11'(H_MAX - OBJ_W);
    localparam logic [10:0]       V_LIM    = 11'(V_MAX - OBJ_H);
    localparam logic [10:0]       H_INIT   = 11'((H_MAX + 1 - OBJ_W) / 2);
    localparam logic [10:0]       V_INIT   = 11'((V_MAX + 1 - OBJ_H) / 2);
    localparam logic [10:0]       STEP     = 11'(SPEED);
    localparam logic signed [7:0] NEG_DZ   = -ACCEL_DZ;
    localparam int                ACW      = FRAMES_PER_ACTION > 1 ? $clog2(FRAMES_PER_ACTION) : 1;
    localparam logic [ACW-1:0]    ACT_LAST = ACW'(FRAMES_PER_ACTION - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_frame_tick;
    logic           r_btn_c_prev;
    logic [ACW-1:0] r_act_cnt;
    logic [10:0]    r_obj_h;
    logic [10:0]    r_obj_v;
    logic [7:0]     r_accel_x_frame;
    logic [7:0]     r_accel_y_frame;
    logic           w_action;
    logic           w_mode_ev;
    logic           w_left;
    logic           w_right;
    logic           w_up;
    logic           w_down;
    logic [10:0]    w_h_inc;
    logic [10:0]    w_v_inc;
    logic [10:0]    w_obj_h_nxt;
    logic [10:0]    w_obj_v_nxt;
    logic           w_unused_h10;

    assign w_unused_h10 = bus.h_coord[10];

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_btn_c_prev <= 1'b0;
            r_act_cnt    <= '0;
        end else begin
            r_frame_tick <= bus.h_coord[9:0] == H_LAST && bus.v_coord == V_LAST;
            r_btn_c_prev <= bus.button_c;
            if (r_frame_tick)
                r_act_cnt <= r_act_cnt == ACT_LAST ? '0 : r_act_cnt + ACW'(1);
        end
    end

    assign w_action  = r_frame_tick && r_act_cnt == '0;
    assign w_mode_ev = bus.button_c && !r_btn_c_prev;

`ifdef PLANE_SPLASH_EN
    logic [31:0] r_splash_cnt;
    logic        w_splash_done;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst)
            r_splash_cnt <= '0;
        else if (r_state == SPLASH)
            r_splash_cnt <= r_splash_cnt + 32'd1;
    end

    assign w_splash_done   = r_splash_cnt == SPLASH_CYCLES - 32'd1;
    assign bus.logo_active = r_state == SPLASH;
`else
    assign bus.logo_active = 1'b0;
`endif

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst)
            r_state <= RST_ST;
        else
            r_state <= w_state_nxt;
    end

    // Mode events arriving during the splash are dropped, not deferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef PLANE_SPLASH_EN
            SPLASH:  if (w_splash_done) w_state_nxt = BUTTONS;
`endif
            BUTTONS: if (w_mode_ev) w_state_nxt = ACCEL;
            ACCEL:   if (w_mode_ev) w_state_nxt = BUTTONS;
            default: w_state_nxt = RST_ST;
        endcase
    end

    // Left/up take priority over right/down in the position muxes below.
    always_comb begin
        w_left  = 1'b0;
        w_right = 1'b0;
        w_up    = 1'b0;
        w_down  = 1'b0;
        if (r_state == BUTTONS) begin
            w_left  = bus.button_l;
            w_right = bus.button_r;
            w_up    = bus.button_u;
            w_down  = bus.button_d;
        end else if (r_state == ACCEL) begin
            w_left  = $signed(bus.accel_y) > ACCEL_DZ;
            w_right = $signed(bus.accel_y) < NEG_DZ;
            w_up    = $signed(bus.accel_x) < NEG_DZ;
            w_down  = $signed(bus.accel_x) > ACCEL_DZ;
        end
    end

    assign w_h_inc     = r_obj_h + STEP;
    assign w_v_inc     = r_obj_v + STEP;
    assign w_obj_h_nxt = w_left  ? (r_obj_h < STEP ? '0 : r_obj_h - STEP) :
                         w_right ? (w_h_inc > H_LIM ? H_LIM : w_h_inc) : r_obj_h;
    assign w_obj_v_nxt = w_up    ? (r_obj_v < STEP ? '0 : r_obj_v - STEP) :
                         w_down  ? (w_v_inc > V_LIM ? V_LIM : w_v_inc) : r_obj_v;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_obj_h         <= H_INIT;
            r_obj_v         <= V_INIT;
            r_accel_x_frame <= '0;
            r_accel_y_frame <= '0;
        end else if (w_action) begin
            r_obj_h         <= w_obj_h_nxt;
            r_obj_v         <= w_obj_v_nxt;
            r_accel_x_frame <= bus.accel_x;
            r_accel_y_frame <= bus.accel_y;
        end
    end

    assign bus.obj_h         = r_obj_h[9:0];
    assign bus.obj_v         = r_obj_v[9:0];
    assign bus.regime        = r_state;
    assign bus.frame_tick    = r_frame_tick;
    assign bus.accel_x_frame = r_accel_x_frame;
    assign bus.accel_y_frame = r_accel_y_frame;
endmodule

// File: tb/tb_plane_motion_ctrl.sv
// tb_plane_motion_ctrl: scoreboard bench with two controllers (slow/fine and fast/coarse) on shared stimulus.
module tb_plane_motion_ctrl;
    typedef struct {
        logic [9:0] h0, v0, h1, v1;
        logic [7:0] ax0, ay0, ay1;
        logic [1:0] rg;
    } exp_t;

    localparam int SP[2] = '{1, 100};
    localparam int DZ[2] = '{0, 8};
`ifdef PLANE_SPLASH_EN
    localparam logic [1:0] RST_RG = 2'b00;
    localparam logic       RST_LOGO = 1'b1;
`else
    localparam logic [1:0] RST_RG = 2'b11;
    localparam logic       RST_LOGO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [10:0] hc = '0;
    logic [9:0] vc = '0;
    logic bc = 0, bu = 0, bd = 0, bl = 0, br = 0;
    logic [7:0] ax = '0, ay = '0;

    int n_tests = 0, n_fail = 0, n_fr = 0, n_ticks = 0;
    int m_h[2], m_v[2], m_cnt0;
    logic [1:0] m_rg;
    logic [7:0] m_ax0, m_ay0, m_ay1;
    exp_t q[$];
    logic seen = 1'b0;

    plane_motion_ctrl_if if0();
    plane_motion_ctrl_if if1();

    assign if0.h_coord = hc;  assign if1.h_coord = hc;
    assign if0.v_coord = vc;  assign if1.v_coord = vc;
    assign if0.button_c = bc; assign if1.button_c = bc;
    assign if0.button_u = bu; assign if1.button_u = bu;
    assign if0.button_d = bd; assign if1.button_d = bd;
    assign if0.button_l = bl; assign if1.button_l = bl;
    assign if0.button_r = br; assign if1.button_r = br;
    assign if0.accel_x = ax;  assign if1.accel_x = ax;
    assign if0.accel_y = ay;  assign if1.accel_y = ay;

    plane_motion_ctrl #(.FRAMES_PER_ACTION(2), .SPLASH_CYCLES(32'd16), .SPEED(1), .ACCEL_DZ(8'sd0))
        dut0 (.pixel_clk(clk), .rst(rst), .bus(if0));
    plane_motion_ctrl #(.FRAMES_PER_ACTION(1), .SPLASH_CYCLES(32'd16), .SPEED(100), .ACCEL_DZ(8'sd8))
        dut1 (.pixel_clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_h = '{369, 369};
        m_v = '{275, 275};
        m_cnt0 = 0;
        m_rg = 2'b11;
        m_ax0 = '0;
        m_ay0 = '0;
        m_ay1 = '0;
    endtask

    function automatic void mv(input int k);
        int axs, ays;
        logic l, r, u, d;
        axs = $signed(ax);
        ays = $signed(ay);
        l = m_rg == 2'b11 ? bl : (m_rg == 2'b10 && ays > DZ[k]);
        r = m_rg == 2'b11 ? br : (m_rg == 2'b10 && ays < -DZ[k]);
        u = m_rg == 2'b11 ? bu : (m_rg == 2'b10 && axs < -DZ[k]);
        d = m_rg == 2'b11 ? bd : (m_rg == 2'b10 && axs > DZ[k]);
        m_h[k] = l ? (m_h[k] < SP[k] ? 0 : m_h[k] - SP[k]) : r ? (m_h[k] + SP[k] > 738 ? 738 : m_h[k] + SP[k]) : m_h[k];
        m_v[k] = u ? (m_v[k] < SP[k] ? 0 : m_v[k] - SP[k]) : d ? (m_v[k] + SP[k] > 549 ? 549 : m_v[k] + SP[k]) : m_v[k];
    endfunction

    // One short frame: end-of-frame coordinates for a cycle, optional mode rise on the action edge.
    task automatic frame(input logic pc);
        exp_t e;
        if (m_cnt0 == 0) begin
            mv(0);
            m_ax0 = ax;
            m_ay0 = ay;
        end
        m_cnt0 = (m_cnt0 + 1) % 2;
        mv(1);
        m_ay1 = ay;
        if (pc) m_rg = m_rg ^ 2'b01;
        e.h0 = 10'(m_h[0]); e.v0 = 10'(m_v[0]);
        e.h1 = 10'(m_h[1]); e.v1 = 10'(m_v[1]);
        e.ax0 = m_ax0; e.ay0 = m_ay0; e.ay1 = m_ay1; e.rg = m_rg;
        q.push_back(e);
        hc = {n_fr[0], 10'd799};
        vc = 10'd599;
        n_fr++;
        @(negedge clk);
        hc = 11'd799;
        vc = 10'd0;
        if (pc) bc = 1'b1;
        @(negedge clk);
        bc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_c();
        bc = 1'b1;
        @(negedge clk);
        m_rg = m_rg ^ 2'b01;
        chk("mode_rg0", if0.regime, m_rg);
        chk("mode_rg1", if1.regime, m_rg);
        bc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (seen) begin
                seen = 1'b0;
                chk("tick_width", if0.frame_tick, 0);
                chk("sb_pop", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("obj_h0", if0.obj_h, e.h0);
                    chk("obj_v0", if0.obj_v, e.v0);
                    chk("obj_h1", if1.obj_h, e.h1);
                    chk("obj_v1", if1.obj_v, e.v1);
                    chk("ax_frame0", if0.accel_x_frame, e.ax0);
                    chk("ay_frame0", if0.accel_y_frame, e.ay0);
                    chk("ay_frame1", if1.accel_y_frame, e.ay1);
                    chk("regime", if0.regime, e.rg);
                end
            end else if (if0.frame_tick) begin
                seen = 1'b1;
                n_ticks++;
            end
        end
    end

    initial begin
        reset_model();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_h0", if0.obj_h, 369);
        chk("rst_v0", if0.obj_v, 275);
        chk("rst_h1", if1.obj_h, 369);
        chk("rst_tick", if0.frame_tick, 0);
        chk("rst_axf", if0.accel_x_frame, 0);
        chk("rst_ayf", if0.accel_y_frame, 0);
        chk("rst_rg", if0.regime, RST_RG);
        chk("rst_logo", if0.logo_active, RST_LOGO);
        rst = 1'b0;
`ifdef PLANE_SPLASH_EN
        bc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("splash_rg", if0.regime, 2'b00);
            chk("splash_logo", if0.logo_active, 1);
            @(negedge clk);
        end
        chk("splash_exit_rg", if0.regime, 2'b11);
        @(negedge clk);
        chk("splash_no_mode", if0.regime, 2'b11);
        bc = 1'b0;
`endif
        chk("btn_rg", if0.regime, 2'b11);
        chk("btn_logo", if0.logo_active, 0);

        bl = 1; br = 1;
        repeat (6) frame(0);
        bl = 0; br = 0; bd = 1;
        repeat (4) frame(0);
        bd = 0; br = 1;
        repeat (4) frame(0);
        br = 0;
        pulse_c();
        ay = 8'hF0; ax = 8'h05;
        repeat (4) frame(0);

        pulse_c();
        ax = 8'h10; bu = 1;
        if (m_cnt0 != 0) frame(0);
        frame(1);
        bu = 0;
        repeat (2) frame(0);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_h0", if0.obj_h, 369);
        chk("arst_v0", if0.obj_v, 275);
        chk("arst_h1", if1.obj_h, 369);
        chk("arst_v1", if1.obj_v, 275);
        chk("arst_rg", if0.regime, RST_RG);
        chk("arst_ayf", if0.accel_y_frame, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        ax = '0; ay = '0;
`ifdef PLANE_SPLASH_EN
        repeat (16) @(negedge clk);
`endif
        chk("post_rst_rg", if0.regime, 2'b11);
        br = 1;
        repeat (2) frame(0);
        br = 0;

        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        chk("tick_count", n_ticks, n_fr);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
